// File: rtl/arp_pkg.sv
// Shared ARP receive definitions: octet offsets within the Ethernet frame,
// expected fixed-field values, arp_bus bit positions and the receiver state type.
package arp_pkg;

  localparam logic [5:0] OFF_ETYPE   = 6'd12;
  localparam logic [5:0] OFF_HTYPE   = 6'd14;
  localparam logic [5:0] OFF_PTYPE   = 6'd16;
  localparam logic [5:0] OFF_HLEN    = 6'd18;
  localparam logic [5:0] OFF_PLEN    = 6'd19;
  localparam logic [5:0] OFF_OPER    = 6'd20;
  localparam logic [5:0] OFF_SHA     = 6'd22;
  localparam logic [5:0] OFF_SPA     = 6'd28;
  localparam logic [5:0] OFF_WR_LAST = 6'd31;
  localparam logic [5:0] OFF_TPA     = 6'd38;
  localparam logic [5:0] OFF_LAST    = 6'd41;

  localparam logic [15:0] ETYPE_ARP  = 16'h0806;
  localparam logic [15:0] HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  HLEN_ETH   = 8'd6;
  localparam logic [7:0]  PLEN_IPV4  = 8'd4;
  localparam logic [15:0] OPER_REQ   = 16'h0001;
  localparam logic [15:0] OPER_REP   = 16'h0002;

  localparam int BUS_WR  = 8;
  localparam int BUS_STB = 9;
  localparam int BUS_OK  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX,
    ST_DROP
  } state_e;

  function automatic logic [5:0] cnt_inc(input logic [5:0] c);
    return (c == 6'h3f) ? c : c + 6'd1;
  endfunction

endpackage

// File: rtl/arp_rx_match.sv
// Per-octet field comparator for the ARP receiver. With ARP_RX_DEST_MAC_CHECK_EN
// defined it also classifies destination-MAC octets as broadcast / our-MAC.
module arp_rx_match
  import arp_pkg::*;
#(
  parameter logic [31:0] IP  = {8'd192, 8'd168, 8'd7, 8'd2}
`ifdef ARP_RX_DEST_MAC_CHECK_EN
  ,
  parameter logic [47:0] MAC = 48'h125555000130
`endif
) (
  input  logic [5:0] cnt_i,
  input  logic [7:0] data_i,
  output logic       checked_o,
  output logic       equal_o
`ifdef ARP_RX_DEST_MAC_CHECK_EN
  ,
  output logic       dst_o,
  output logic       dst_bc_o,
  output logic       dst_uc_o
`endif
);

  logic [7:0] exp_oct;

  always_comb begin
    checked_o = 1'b1;
    exp_oct   = 8'h00;
    case (cnt_i)
      OFF_ETYPE:          exp_oct = ETYPE_ARP[15:8];
      OFF_ETYPE + 6'd1:   exp_oct = ETYPE_ARP[7:0];
      OFF_HTYPE:          exp_oct = HTYPE_ETH[15:8];
      OFF_HTYPE + 6'd1:   exp_oct = HTYPE_ETH[7:0];
      OFF_PTYPE:          exp_oct = PTYPE_IPV4[15:8];
      OFF_PTYPE + 6'd1:   exp_oct = PTYPE_IPV4[7:0];
      OFF_HLEN:           exp_oct = HLEN_ETH;
      OFF_PLEN:           exp_oct = PLEN_IPV4;
      OFF_OPER:           exp_oct = OPER_REQ[15:8];
      OFF_OPER + 6'd1:    exp_oct = OPER_REQ[7:0];
      OFF_TPA:            exp_oct = IP[31:24];
      OFF_TPA + 6'd1:     exp_oct = IP[23:16];
      OFF_TPA + 6'd2:     exp_oct = IP[15:8];
      OFF_TPA + 6'd3:     exp_oct = IP[7:0];
      default:            checked_o = 1'b0;
    endcase
  end

  assign equal_o = (data_i == exp_oct);

`ifdef ARP_RX_DEST_MAC_CHECK_EN
  logic [7:0] mac_oct;

  always_comb begin
    dst_o   = 1'b1;
    mac_oct = 8'h00;
    case (cnt_i)
      6'd0:    mac_oct = MAC[47:40];
      6'd1:    mac_oct = MAC[39:32];
      6'd2:    mac_oct = MAC[31:24];
      6'd3:    mac_oct = MAC[23:16];
      6'd4:    mac_oct = MAC[15:8];
      6'd5:    mac_oct = MAC[7:0];
      default: dst_o   = 1'b0;
    endcase
  end

  assign dst_bc_o = (data_i == 8'hff);
  assign dst_uc_o = (data_i == mac_oct);
`endif

endmodule

// File: rtl/arp_rx.sv
// ARP request receiver: parses the octet stream, forwards sender MAC/IP on arp_bus
// and frames each packet with start/end strobes. Optional ARP_RX_DEST_MAC_CHECK_EN.
module arp_rx
  import arp_pkg::*;
#(
  parameter logic [31:0] IP  = {8'd192, 8'd168, 8'd7, 8'd2},
  parameter logic [47:0] MAC = 48'h125555000130
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        rx_crc_ok,
  output logic [10:0] arp_bus
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        match_q, match_d;
  logic        complete_q, complete_d;
  logic        crc_q, crc_d;
  logic [10:0] bus_q, bus_d;
  logic        chk, eq, octet_ok, in_wr, dst_ok;

`ifdef ARP_RX_DEST_MAC_CHECK_EN
  logic dst, dst_bc, dst_uc;
  logic bc_q, bc_d, uc_q, uc_d;
`endif

  arp_rx_match #(
    .IP  (IP)
`ifdef ARP_RX_DEST_MAC_CHECK_EN
    ,
    .MAC (MAC)
`endif
  ) u_match (
    .cnt_i     (cnt_q),
    .data_i    (rx_data),
    .checked_o (chk),
    .equal_o   (eq)
`ifdef ARP_RX_DEST_MAC_CHECK_EN
    ,
    .dst_o     (dst),
    .dst_bc_o  (dst_bc),
    .dst_uc_o  (dst_uc)
`endif
  );

  assign octet_ok = !(chk && !eq);
  assign in_wr    = (cnt_q >= OFF_SHA) && (cnt_q <= OFF_WR_LAST);

`ifdef ARP_RX_DEST_MAC_CHECK_EN
  // Broadcast and unicast are tracked separately so a mixed address never passes.
  assign dst_ok = bc_q | uc_q;
`else
  assign dst_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    complete_d = complete_q;
    crc_d      = crc_q;
    bus_d      = 11'b0;
`ifdef ARP_RX_DEST_MAC_CHECK_EN
    bc_d       = bc_q;
    uc_d       = uc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = 6'd0;
        if (rx_strobe) begin
          // cnt_q is 0 here, so the first octet is checked in this cycle.
          state_d          = ST_RX;
          cnt_d            = 6'd1;
          match_d          = octet_ok;
          complete_d       = 1'b0;
          crc_d            = rx_crc_ok;
          bus_d[BUS_STB]   = 1'b1;
`ifdef ARP_RX_DEST_MAC_CHECK_EN
          bc_d             = dst_bc;
          uc_d             = dst_uc;
`endif
        end
      end
      ST_RX: begin
        if (rx_strobe) begin
          cnt_d      = cnt_inc(cnt_q);
          match_d    = match_q & octet_ok;
          complete_d = complete_q | (cnt_q == OFF_LAST);
          crc_d      = rx_crc_ok;
          if (in_wr) begin
            bus_d[BUS_WR]  = 1'b1;
            bus_d[7:0]     = rx_data;
          end
`ifdef ARP_RX_DEST_MAC_CHECK_EN
          if (dst) begin
            bc_d = bc_q & dst_bc;
            uc_d = uc_q & dst_uc;
          end
`endif
        end else begin
          state_d         = ST_IDLE;
          cnt_d           = 6'd0;
          bus_d[BUS_STB]  = 1'b1;
          bus_d[BUS_OK]   = match_q & complete_q & crc_q & dst_ok;
        end
      end
      ST_DROP: begin
        cnt_d = 6'd0;
        if (!rx_strobe) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset lands in DROP so a packet already in flight is ignored entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DROP;
      cnt_q      <= 6'd0;
      match_q    <= 1'b0;
      complete_q <= 1'b0;
      crc_q      <= 1'b0;
      bus_q      <= 11'b0;
`ifdef ARP_RX_DEST_MAC_CHECK_EN
      bc_q       <= 1'b0;
      uc_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      complete_q <= complete_d;
      crc_q      <= crc_d;
      bus_q      <= bus_d;
`ifdef ARP_RX_DEST_MAC_CHECK_EN
      bc_q       <= bc_d;
      uc_q       <= uc_d;
`endif
    end
  end

  assign arp_bus = bus_q;

endmodule
